// File: rtl/srec_pkg.sv
// ---------------------------------------------------------------------------
// srec_pkg
// Shared definitions for the S-record loader: FSM state encoding, record
// classification, fixed access-size code, ASCII constants and the two small
// character decoders (hex digit and record-type digit).
// ---------------------------------------------------------------------------
package srec_pkg;

    // access_size code driven on every write (one 32-bit word)
    localparam logic [1:0] ACCESS_WORD = 2'b00;
    // largest S-record byte count accepted
    localparam logic [7:0] MAX_COUNT   = 8'd64;

    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TYPE,
        ST_COUNT,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_EOL,
        ST_DONE,
        ST_ERROR
    } state_t;

    // What a record does once it has been validated
    typedef enum logic [1:0] {
        REC_INFO,   // S0 header / S5 count: checksummed, never written
        REC_DATA,   // S1/S2/S3: data bytes become word writes
        REC_TERM    // S7/S8/S9: address is the entry PC
    } rec_kind_t;

    typedef struct packed {
        logic      ok;
        rec_kind_t kind;
        logic [2:0] addr_bytes;
    } rec_type_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } nibble_t;

    // ASCII hex digit ('0'-'9', 'A'-'F', 'a'-'f') -> 4-bit value
    function automatic nibble_t hex_decode(input logic [7:0] c);
        nibble_t n;
        n.valid = 1'b0;
        n.value = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            n.valid = 1'b1;
            n.value = 4'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            n.valid = 1'b1;
            n.value = 4'(c - 8'h37);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            n.valid = 1'b1;
            n.value = 4'(c - 8'h57);
        end
        return n;
    endfunction

    // Character following 'S' -> record class and address field width
    function automatic rec_type_t decode_type(input logic [7:0] c);
        rec_type_t t;
        t.ok         = 1'b1;
        t.kind       = REC_INFO;
        t.addr_bytes = 3'd2;
        case (c)
            8'h30, 8'h35: begin t.kind = REC_INFO; t.addr_bytes = 3'd2; end  // S0, S5
            8'h31:        begin t.kind = REC_DATA; t.addr_bytes = 3'd2; end  // S1
            8'h32:        begin t.kind = REC_DATA; t.addr_bytes = 3'd3; end  // S2
            8'h33:        begin t.kind = REC_DATA; t.addr_bytes = 3'd4; end  // S3
            8'h37:        begin t.kind = REC_TERM; t.addr_bytes = 3'd4; end  // S7
            8'h38:        begin t.kind = REC_TERM; t.addr_bytes = 3'd3; end  // S8
            8'h39:        begin t.kind = REC_TERM; t.addr_bytes = 3'd2; end  // S9
            default:      t.ok = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/hex_nibble_decoder.sv
// ---------------------------------------------------------------------------
// hex_nibble_decoder
// Purely combinational ASCII hex digit decoder.
// Ports:
//   ascii  in   8  character under test
//   value  out  4  decoded nibble (0 when not a hex digit)
//   valid  out  1  ascii is a legal hex digit
// ---------------------------------------------------------------------------
module hex_nibble_decoder
    import srec_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [3:0] value,
    output logic       valid
);

    nibble_t nib;

    assign nib   = hex_decode(ascii);
    assign value = nib.value;
    assign valid = nib.valid;

endmodule

// File: rtl/srec_loader.sv
// ---------------------------------------------------------------------------
// srec_loader
// Parses an ASCII Motorola S-record stream, validates every record (format,
// length, alignment, checksum) and turns S1/S2/S3 payloads into big-endian
// 32-bit word writes for the instruction memory. A termination record
// (S7/S8/S9) hands over the entry PC, drops srec_parse and pulses done.
// Any fault parks the loader in a sticky error state until reset.
// Ports:
//   clk               in   1   system clock
//   reset             in   1   synchronous, active-high reset
//   byte_in           in   8   ASCII character
//   byte_valid        in   1   byte_in valid this cycle
//   byte_ready        out  1   byte_in accepted this cycle when valid
//   srec_parse        out  1   1 while loading (selects SREC side of muxes)
//   srec_address      out  32  word-aligned write address
//   srec_data_in      out  32  write data, first record byte in bits 31:24
//   srec_rw           out  1   single-cycle write strobe
//   srec_access_size  out  2   constant ACCESS_WORD
//   entry_pc          out  32  start address from the termination record
//   done              out  1   one-cycle pulse after a valid termination record
//   error             out  1   sticky fault flag
// ---------------------------------------------------------------------------
module srec_loader
    import srec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        srec_parse,
    output logic [31:0] srec_address,
    output logic [31:0] srec_data_in,
    output logic        srec_rw,
    output logic [1:0]  srec_access_size,
    output logic [31:0] entry_pc,
    output logic        done,
    output logic        error
);

    state_t     state, state_next;
    rec_kind_t  rec_kind;
    rec_type_t  typ;
    logic [2:0] addr_bytes;
    logic [7:0] data_len;     // payload bytes still implied by the count field
    logic [7:0] byte_cnt;     // bytes left in the current ADDR/DATA field
    logic [7:0] sum;          // running checksum over count/addr/data bytes
    logic [1:0] word_cnt;     // byte position inside the current data word
    logic [23:0] word_sr;     // first three bytes of the word being built
    logic [31:0] addr;
    logic [31:0] addr_next;
    logic       nib_phase;    // 1 = high nibble already captured
    logic [3:0] hi_nib;
    logic [3:0] nib;
    logic       nib_ok;
    logic [7:0] byte_val;
    logic [7:0] min_count;
    logic       xfer, hex_state, hex_bad, byte_done, last_byte, writable;
    logic       is_space, is_eol;

    hex_nibble_decoder u_hex (
        .ascii (byte_in),
        .value (nib),
        .valid (nib_ok)
    );

    assign typ       = decode_type(byte_in);
    assign byte_ready = !(state == ST_WRITE || state == ST_DONE);
    assign xfer      = byte_valid && byte_ready;
    assign hex_state = (state == ST_COUNT) || (state == ST_ADDR) ||
                       (state == ST_DATA)  || (state == ST_CSUM);
    assign hex_bad   = xfer && hex_state && !nib_ok;
    assign byte_done = xfer && hex_state && nib_ok && nib_phase;
    assign byte_val  = {hi_nib, nib};
    assign last_byte = (byte_cnt == 8'd1);
    assign writable  = (rec_kind == REC_DATA);
    assign min_count = {5'b0, addr_bytes} + 8'd1;
    // Address including the byte completing right now; used for the alignment check
    assign addr_next = {addr[23:0], byte_val};
    assign is_space  = (byte_in == ASCII_CR) || (byte_in == ASCII_LF) || (byte_in == ASCII_SP);
    assign is_eol    = (byte_in == ASCII_CR) || (byte_in == ASCII_LF);

    assign srec_rw          = (state == ST_WRITE);
    assign srec_parse       = (state != ST_DONE);
    assign error            = (state == ST_ERROR);
    assign srec_access_size = ACCESS_WORD;
    assign srec_address     = addr;

    always_comb begin
        // NOTE: default first, so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (byte_in == ASCII_S) state_next = ST_TYPE;
                    else if (!is_space)     state_next = ST_ERROR;
                end
            end
            ST_TYPE: begin
                if (xfer) state_next = typ.ok ? ST_COUNT : ST_ERROR;
            end
            ST_COUNT: begin
                if (hex_bad) state_next = ST_ERROR;
                else if (byte_done) begin
                    if (byte_val < min_count || byte_val > MAX_COUNT) state_next = ST_ERROR;
                    else                                              state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hex_bad) state_next = ST_ERROR;
                else if (byte_done && last_byte) begin
                    if (writable && (addr_next[1:0] != 2'b00 || data_len[1:0] != 2'b00))
                        state_next = ST_ERROR;
                    else if (data_len == 8'd0)
                        state_next = ST_CSUM;
                    else
                        state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hex_bad) state_next = ST_ERROR;
                else if (byte_done) begin
                    if (writable && word_cnt == 2'd3) state_next = ST_WRITE;
                    else if (last_byte)               state_next = ST_CSUM;
                end
            end
            ST_WRITE: begin
                state_next = (byte_cnt == 8'd0) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (hex_bad) state_next = ST_ERROR;
                else if (byte_done) state_next = (8'(sum + byte_val) == 8'hFF) ? ST_EOL : ST_ERROR;
            end
            ST_EOL: begin
                if (xfer) begin
                    if (!is_eol)                     state_next = ST_ERROR;
                    else if (rec_kind == REC_TERM)   state_next = ST_DONE;
                    else                             state_next = ST_IDLE;
                end
            end
            ST_DONE:  state_next = ST_DONE;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rec_kind     <= REC_INFO;
            addr_bytes   <= 3'd0;
            data_len     <= 8'd0;
            byte_cnt     <= 8'd0;
            sum          <= 8'd0;
            word_cnt     <= 2'd0;
            word_sr      <= 24'd0;
            addr         <= 32'd0;
            nib_phase    <= 1'b0;
            hi_nib       <= 4'd0;
            srec_data_in <= 32'd0;
            entry_pc     <= 32'd0;
            done         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; every read below sees the pre-edge value.
            state <= state_next;
            done  <= 1'b0;

            if (xfer && hex_state && nib_ok && !nib_phase) begin
                hi_nib    <= nib;
                nib_phase <= 1'b1;
            end
            if (byte_done) begin
                nib_phase <= 1'b0;
                sum       <= sum + byte_val;
            end

            case (state)
                ST_TYPE: begin
                    if (xfer) begin
                        rec_kind   <= typ.kind;
                        addr_bytes <= typ.addr_bytes;
                        sum        <= 8'd0;
                        nib_phase  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (byte_done) begin
                        data_len <= byte_val - min_count;
                        byte_cnt <= {5'b0, addr_bytes};
                        addr     <= 32'd0;   // short address fields are zero-extended
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        addr     <= addr_next;
                        byte_cnt <= last_byte ? data_len : byte_cnt - 8'd1;
                        word_cnt <= 2'd0;
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        word_sr  <= {word_sr[15:0], byte_val};
                        byte_cnt <= byte_cnt - 8'd1;
                        word_cnt <= word_cnt + 2'd1;
                        if (writable && word_cnt == 2'd3)
                            srec_data_in <= {word_sr, byte_val};
                    end
                end
                ST_WRITE: addr <= addr + 32'd4;
                ST_EOL: begin
                    if (xfer && is_eol && rec_kind == REC_TERM) begin
                        entry_pc <= addr;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_srec_loader.sv
// ---------------------------------------------------------------------------
// tb_srec_loader
// Directed and randomized S-record streams against srec_loader. The bench
// formats records itself (count and checksum from plain arithmetic), predicts
// the resulting word writes from the record contents, and compares them with
// the writes observed on the SREC port.
// ---------------------------------------------------------------------------
module tb_srec_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        srec_parse;
    logic [31:0] srec_address;
    logic [31:0] srec_data_in;
    logic        srec_rw;
    logic [1:0]  srec_access_size;
    logic [31:0] entry_pc;
    logic        done;
    logic        error;

    srec_loader dut (
        .clk              (clk),
        .reset            (reset),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .srec_parse       (srec_parse),
        .srec_address     (srec_address),
        .srec_data_in     (srec_data_in),
        .srec_rw          (srec_rw),
        .srec_access_size (srec_access_size),
        .entry_pc         (entry_pc),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [63:0] got_q[$];   // {address, data} per observed write cycle
    logic [63:0] exp_q[$];
    logic [7:0]  payload[$];
    string       bad_q[$];

    // Write / done observer, sampled away from the active edge
    always @(negedge clk) begin
        if (srec_rw) got_q.push_back({srec_address, srec_data_in});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    // Offer one byte from a negedge; returns at the negedge after it was taken
    task automatic send_byte(input logic [7:0] c);
        bit sent = 1'b0;
        byte_in = c;
        byte_valid = 1'b1;
        for (int i = 0; i < 8 && !sent; i++) begin
            sent = byte_ready;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("byte_accept", 64'(sent), 64'd1);
    endtask

    task automatic send_str(input string s, input int gap_max);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    function automatic string hex_byte(input logic [7:0] b, input bit lower);
        return lower ? $sformatf("%02x", b) : $sformatf("%02X", b);
    endfunction

    // Format a record from its type digit, address and the global payload
    function automatic string make_rec(input string t, input int abytes, input logic [31:0] a,
                                       input bit lower, input logic [7:0] adj);
        logic [7:0] cnt, sum, b;
        string s;
        cnt = 8'(abytes + payload.size() + 1);
        sum = cnt;
        s = {"S", t, hex_byte(cnt, lower)};
        for (int k = abytes - 1; k >= 0; k--) begin
            b = a[k*8 +: 8];
            sum = sum + b;
            s = {s, hex_byte(b, lower)};
        end
        foreach (payload[k]) begin
            sum = sum + payload[k];
            s = {s, hex_byte(payload[k], lower)};
        end
        return {s, hex_byte(8'(~sum + adj), lower)};
    endfunction

    // Data records write their payload as consecutive big-endian words
    function automatic void expect_writes(input string t, input logic [31:0] a);
        if (t == "1" || t == "2" || t == "3")
            for (int w = 0; w < payload.size() / 4; w++)
                exp_q.push_back({a + 32'(4 * w), payload[4*w], payload[4*w+1],
                                 payload[4*w+2], payload[4*w+3]});
    endfunction

    task automatic compare_writes(input string tag);
        #1;
        check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_wr"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic fill_payload(input int nbytes);
        payload.delete();
        for (int i = 0; i < nbytes; i++) payload.push_back(8'($urandom));
    endtask

    initial begin
        string r, t;
        logic [31:0] a, mask;
        int tsel;
        bit lower;

        // ---- reset values
        repeat (2) @(negedge clk);
        check("rst_parse", 64'(srec_parse), 64'd1);
        check("rst_ready", 64'(byte_ready), 64'd1);
        check("rst_rw",    64'(srec_rw), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_addr",  64'(srec_address), 64'd0);
        check("rst_data",  64'(srec_data_in), 64'd0);
        check("rst_entry", 64'(entry_pc), 64'd0);
        check("rst_size",  64'(srec_access_size), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---- basic S1, strobe timing and stall of the byte offered during the write
        send_str("S1070000", 0);
        send_str("0102030", 0);
        send_byte("4");
        check("s1_rw_lat",   64'(srec_rw), 64'd1);
        check("s1_ready_wr", 64'(byte_ready), 64'd0);
        check("s1_wr_addr",  64'(srec_address), 64'h0);
        check("s1_wr_data",  64'(srec_data_in), 64'h01020304);
        send_str("EE\n", 0);
        exp_q.push_back({32'h0, 32'h01020304});
        compare_writes("s1_basic");
        check("s1_error", 64'(error), 64'd0);

        // ---- two-word S3 with CRLF terminator
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_str({make_rec("3", 4, 32'h80020000, 1'b0, 8'd0), "\r\n"}, 0);
        expect_writes("3", 32'h80020000);
        compare_writes("s3_two");

        // ---- randomized data records, mixed case, idle gaps
        for (int n = 0; n < 12; n++) begin
            tsel = int'($urandom_range(1, 3));
            t = (tsel == 1) ? "1" : (tsel == 2) ? "2" : "3";
            mask = (tsel == 1) ? 32'h0000FFFC : (tsel == 2) ? 32'h00FFFFFC : 32'hFFFFFFFC;
            a = $urandom & mask;
            lower = 1'($urandom_range(0, 1));
            fill_payload(4 * int'($urandom_range(1, 4)));
            send_str({make_rec(t, tsel + 1, a, lower, 8'd0), "\n"}, 2);
            expect_writes(t, a);
            compare_writes("rand_rec");
        end
        check("rand_error", 64'(error), 64'd0);

        // ---- address wraps past 2^32
        fill_payload(8);
        send_str({make_rec("3", 4, 32'hFFFFFFFC, 1'b0, 8'd0), "\n"}, 0);
        expect_writes("3", 32'hFFFFFFFC);
        compare_writes("wrap");

        // ---- S0 header (odd length) and S5 count are never written
        fill_payload(5);
        send_str({make_rec("0", 2, 32'h0, 1'b0, 8'd0), "\n"}, 0);
        payload.delete();
        send_str({make_rec("5", 2, 32'h0003, 1'b1, 8'd0), "\n"}, 0);
        compare_writes("hdr");
        check("hdr_error", 64'(error), 64'd0);

        // ---- largest legal count (64): S2 with 15 words
        fill_payload(60);
        send_str({make_rec("2", 3, 32'h00001000, 1'b0, 8'd0), "\n"}, 0);
        expect_writes("2", 32'h00001000);
        compare_writes("max_cnt");
        check("max_cnt_error", 64'(error), 64'd0);

        // ---- reset in the middle of a word, then full record resent
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        r = make_rec("3", 4, 32'h80020000, 1'b0, 8'd0);
        send_str(r.substr(0, 17), 0);
        do_reset();
        send_str({r, "\n"}, 0);
        expect_writes("3", 32'h80020000);
        compare_writes("mid_reset");

        // ---- bad checksum: the write already issued stays, later records are ignored
        do_reset();
        fill_payload(4);
        send_str({make_rec("1", 2, 32'h00000100, 1'b0, 8'd1), "\n"}, 0);
        expect_writes("1", 32'h00000100);
        fill_payload(4);
        send_str({make_rec("1", 2, 32'h00000200, 1'b0, 8'd0), "\n"}, 0);
        compare_writes("bad_csum");
        check("bad_csum_err",   64'(error), 64'd1);
        check("bad_csum_parse", 64'(srec_parse), 64'd1);

        // ---- malformed streams: each must raise error without any write
        fill_payload(4);
        bad_q.push_back({make_rec("1", 2, 32'h00000002, 1'b0, 8'd0), "\n"});  // misaligned
        fill_payload(3);
        bad_q.push_back({make_rec("1", 2, 32'h00000010, 1'b0, 8'd0), "\n"});  // short payload
        fill_payload(60);
        bad_q.push_back({make_rec("3", 4, 32'h00000010, 1'b0, 8'd0), "\n"});  // count 65
        payload.delete();
        bad_q.push_back({make_rec("0", 2, 32'h0, 1'b0, 8'd0), "S"});          // no EOL
        bad_q.push_back("S1020000FD\n");                                     // count too small
        bad_q.push_back("S4030000FC\n");                                     // unknown type
        bad_q.push_back("S1070000G1020304EE\n");                             // non-hex digit
        bad_q.push_back("X");                                                // junk in IDLE
        foreach (bad_q[i]) begin
            do_reset();
            send_str(bad_q[i], 0);
            send_str("S107000001020304EE\n", 0);   // drained, never written
            compare_writes("bad_rec");
            check("bad_error", 64'(error), 64'd1);
            check("bad_parse", 64'(srec_parse), 64'd1);
            check("bad_ready", 64'(byte_ready), 64'd1);
        end

        // ---- S7 termination after a data record
        do_reset();
        fill_payload(4);
        send_str({make_rec("1", 2, 32'h00000040, 1'b0, 8'd0), "\n"}, 0);
        expect_writes("1", 32'h00000040);
        payload.delete();
        send_str({make_rec("7", 4, 32'h80020000, 1'b0, 8'd0), "\n"}, 0);
        repeat (5) @(negedge clk);
        compare_writes("s7");
        check("s7_entry", 64'(entry_pc), 64'h80020000);
        check("s7_done",  64'(done_cnt), 64'd1);
        check("s7_parse", 64'(srec_parse), 64'd0);
        check("s7_ready", 64'(byte_ready), 64'd0);
        check("s7_error", 64'(error), 64'd0);

        // ---- S8 and S9 entry points (24- and 16-bit, zero-extended)
        do_reset();
        a = $urandom & 32'h00FFFFFF;
        send_str({make_rec("8", 3, a, 1'b1, 8'd0), "\n"}, 0);
        repeat (3) @(negedge clk);
        check("s8_entry", 64'(entry_pc), 64'(a));
        check("s8_done",  64'(done_cnt), 64'd1);
        do_reset();
        send_str({make_rec("9", 2, 32'h00001234, 1'b0, 8'd0), "\r"}, 0);
        repeat (3) @(negedge clk);
        check("s9_entry", 64'(entry_pc), 64'h00001234);
        check("s9_done",  64'(done_cnt), 64'd1);
        check("s9_parse", 64'(srec_parse), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
